pal_sweep_capture: RTL and testbench

- Test-harness stage wrapped around the 4-input/5-output PAL block. It sits directly upstream, driving A,B,C,D, and directly downstream, consuming F1..F5.
- On start, it sweeps all 16 input vectors and holds each one for a programmable settle time.
- It samples the PAL outputs into a 16-entry truth-table buffer and accumulates an XOR signature.
- It then streams the table out over a valid/ready interface for checking or logging.

---
 rtl/pal_sweep_capture_if.sv | 14 +
 rtl/pal_sweep_capture.sv | 110 +++++++++++
 tb/tb_pal_sweep_capture.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pal_sweep_capture_if.sv
// Read-out channel of the PAL sweep/capture stage: one truth-table entry per transfer.
// Handshake: a transfer happens on any rising edge where rd_valid && rd_ready; the master
// holds rd_data stable while rd_valid is high and rd_ready is low, and never drops rd_valid
// until the entry is taken. rd_ready may be driven without looking at rd_valid.
interface pal_sweep_capture_if #(
  parameter int DATA_W = 9
) ();
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;

  modport master (output rd_valid, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/pal_sweep_capture.sv
// Sweeps every PAL input vector, holds each for SETTLE_CYCLES, captures the outputs into a
// truth table with an XOR signature, then streams {index, outputs} over a valid/ready channel.
module pal_sweep_capture #(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_IN        = 4,
  parameter int NUM_OUT       = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [NUM_IN-1:0]   pal_in,
  input  logic [NUM_OUT-1:0]  pal_out,
  pal_sweep_capture_if.master rd,
  output logic [NUM_OUT-1:0]  signature,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    STREAM = 2'd2
  } state_t;

  localparam int                DEPTH    = 2 ** NUM_IN;
  localparam logic [NUM_IN-1:0] LAST_IDX = {NUM_IN{1'b1}};
  localparam logic [7:0]        CNT_LAST = 8'(SETTLE_CYCLES - 1);

  state_t              state;
  logic [NUM_IN-1:0]   idx;
  logic [NUM_IN-1:0]   rd_idx;
  logic [NUM_IN-1:0]   rd_idx_nxt;
  logic [7:0]          cnt;
  logic [NUM_OUT-1:0]  mem [DEPTH];
  logic                sample_en;
  logic                xfer;

  assign sample_en  = (state == SETTLE) && (cnt == CNT_LAST);
  assign xfer       = (state == STREAM) && rd.rd_valid && rd.rd_ready;
  assign rd_idx_nxt = rd_idx + 1'b1;
  assign state_dbg  = state;

  // Table storage survives reset; only the control path is cleared.
  always_ff @(posedge clk) begin
    if (sample_en) mem[idx] <= pal_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pal_in      <= '0;
      idx         <= '0;
      cnt         <= '0;
      rd_idx      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      signature   <= '0;
      rd.rd_valid <= 1'b0;
      rd.rd_data  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pal_in    <= '0;
            idx       <= '0;
            cnt       <= '0;
            signature <= '0;
            busy      <= 1'b1;
            state     <= SETTLE;
          end
        end
        SETTLE: begin
          if (sample_en) begin
            cnt       <= '0;
            signature <= signature ^ pal_out;
            if (idx != LAST_IDX) begin
              idx    <= idx + 1'b1;
              pal_in <= idx + 1'b1;
            end else begin
              // Entry 0 was captured long before this edge, so it can be presented now.
              state       <= STREAM;
              rd_idx      <= '0;
              rd.rd_valid <= 1'b1;
              rd.rd_data  <= {{NUM_IN{1'b0}}, mem[0]};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STREAM: begin
          if (xfer) begin
            if (rd_idx != LAST_IDX) begin
              rd_idx     <= rd_idx_nxt;
              rd.rd_data <= {rd_idx_nxt, mem[rd_idx_nxt]};
            end else begin
              rd.rd_valid <= 1'b0;
              done        <= 1'b1;
              busy        <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pal_sweep_capture.sv
// Bench for pal_sweep_capture: two instances (settle 3 and settle 1) driven from a random
// truth table, checked against a queue of expected {index, outputs} entries.
module tb_pal_sweep_capture;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic rd_ready = 1'b0;
  logic sel = 1'b0;   // 0 selects the settle-3 instance, 1 the settle-1 instance

  int checks = 0;
  int passes = 0;

  logic [4:0] tbl [16];
  logic [8:0] exp_q [$];

  always #5 clk = ~clk;

  logic       start3, start1, busy3, busy1, done3, done1;
  logic [3:0] pal_in3, pal_in1;
  logic [4:0] pal_out3, pal_out1, sig3, sig1;
  logic [1:0] st3, st1;

  pal_sweep_capture_if #(.DATA_W(9)) if3 ();
  pal_sweep_capture_if #(.DATA_W(9)) if1 ();

  assign start3        = start & ~sel;
  assign start1        = start & sel;
  assign if3.rd_ready  = rd_ready & ~sel;
  assign if1.rd_ready  = rd_ready & sel;
  assign pal_out3      = tbl[pal_in3];
  assign pal_out1      = tbl[pal_in1];

  pal_sweep_capture #(.SETTLE_CYCLES(3), .NUM_IN(4), .NUM_OUT(5)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3),
    .pal_in(pal_in3), .pal_out(pal_out3), .rd(if3), .signature(sig3), .state_dbg(st3)
  );

  pal_sweep_capture #(.SETTLE_CYCLES(1), .NUM_IN(4), .NUM_OUT(5)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .pal_in(pal_in1), .pal_out(pal_out1), .rd(if1), .signature(sig1), .state_dbg(st1)
  );

  logic [3:0] o_pal_in;
  logic       o_busy, o_done, o_valid;
  logic [8:0] o_data;
  logic [4:0] o_sig;

  assign o_pal_in = sel ? pal_in1     : pal_in3;
  assign o_busy   = sel ? busy1       : busy3;
  assign o_done   = sel ? done1       : done3;
  assign o_valid  = sel ? if1.rd_valid : if3.rd_valid;
  assign o_data   = sel ? if1.rd_data  : if3.rd_data;
  assign o_sig    = sel ? sig1        : sig3;

  task automatic fill_random();
    for (int i = 0; i < 16; i++) tbl[i] = 5'($urandom_range(0, 31));
  endtask

  // One full sweep plus stream on the selected instance, checked cycle by cycle.
  task automatic sweep(input int stall_at, input int stall_n, input bit poke,
                       input bit rand_rdy, input bit chain_in, input bit chain_out);
    int         s;
    int         budget;
    int         stalled;
    logic [4:0] exp_sig;
    logic [8:0] head;
    logic       ready;
    bit         first;
    s = sel ? 1 : 3;
    exp_q.delete();
    exp_sig = '0;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back({4'(i), tbl[i]});
      exp_sig = exp_sig ^ tbl[i];
    end
    if (!chain_in) begin
      @(negedge clk);
      start = 1'b1;
    end
    @(posedge clk);
    for (int m = 0; m < 16 * s; m++) begin
      @(negedge clk);
      start = poke && (m == 7 * s + 1);
      checks++;
      if ({o_pal_in, o_busy, o_valid, o_done} !== {4'(m / s), 1'b1, 1'b0, 1'b0})
        $display("FAIL sweep_step m=%0d: got pal_in=%0d busy=%b valid=%b done=%b, expected pal_in=%0d busy=1 valid=0 done=0",
                 m, o_pal_in, o_busy, o_valid, o_done, m / s);
      else passes++;
      @(posedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({o_valid, o_pal_in} !== {1'b1, 4'hf})
      $display("FAIL valid_rise: got valid=%b pal_in=%0d, expected valid=1 pal_in=15", o_valid, o_pal_in);
    else passes++;
    budget  = 400;
    stalled = 0;
    first   = 1'b1;
    while (exp_q.size() > 0 && budget > 0) begin
      head = exp_q[0];
      checks++;
      if ({o_valid, o_data, o_done} !== {1'b1, head, 1'b0})
        $display("FAIL stream_data: got valid=%b data=%h done=%b, expected valid=1 data=%h done=0",
                 o_valid, o_data, o_done, head);
      else passes++;
      if (stall_at >= 0 && int'(head[8:5]) == stall_at && stalled < stall_n) begin
        ready = 1'b0;
        stalled++;
      end else begin
        ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      rd_ready = ready;
      start    = poke && first;
      first    = 1'b0;
      @(posedge clk);
      if (ready) void'(exp_q.pop_front());
      @(negedge clk);
      budget--;
    end
    rd_ready = 1'b0;
    start    = 1'b0;
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL stream_timeout: got %0d entries left, expected 0", exp_q.size());
    else passes++;
    checks++;
    if ({o_done, o_busy, o_valid, o_sig, o_pal_in} !== {1'b1, 1'b0, 1'b0, exp_sig, 4'hf})
      $display("FAIL done_cycle: got done=%b busy=%b valid=%b sig=%b pal_in=%0d, expected done=1 busy=0 valid=0 sig=%b pal_in=15",
               o_done, o_busy, o_valid, o_sig, o_pal_in, exp_sig);
    else passes++;
    if (chain_out) begin
      start = 1'b1;
    end else begin
      @(negedge clk);
      checks++;
      if ({o_done, o_busy, o_sig} !== {1'b0, 1'b0, exp_sig})
        $display("FAIL done_pulse: got done=%b busy=%b sig=%b, expected done=0 busy=0 sig=%b",
                 o_done, o_busy, o_sig, exp_sig);
      else passes++;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({pal_in3, busy3, done3, if3.rd_valid, if3.rd_data, sig3,
           pal_in1, busy1, done1, if1.rd_valid, if1.rd_data, sig1} !== 42'h0)
        $display("FAIL reset_held: got dut3 pal_in=%0d busy=%b valid=%b sig=%b dut1 pal_in=%0d busy=%b, expected all 0",
                 pal_in3, busy3, if3.rd_valid, sig3, pal_in1, busy1);
      else passes++;
    end
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if ({pal_in3, busy3, done3, if3.rd_valid, sig3, pal_in1, busy1, done1, if1.rd_valid, sig1} !== 24'h0)
        $display("FAIL reset_idle: got dut3 pal_in=%0d busy=%b done=%b valid=%b sig=%b, expected all 0",
                 pal_in3, busy3, done3, if3.rd_valid, sig3);
      else passes++;
    end
  endtask

  task automatic test_sweep_basic();
    sel = 1'b0;
    for (int i = 0; i < 16; i++) tbl[i] = (i == 15) ? 5'b10000 : 5'b00000;
    sweep(-1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    sel = 1'b0;
    fill_random();
    sweep(5, 4, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_start_ignored();
    sel = 1'b0;
    fill_random();
    sweep(-1, 0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    sel = 1'b0;
    fill_random();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (27) @(negedge clk);
    checks++;
    if (pal_in3 !== 4'd9)
      $display("FAIL abort_point: got pal_in=%0d, expected 9", pal_in3);
    else passes++;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({pal_in3, busy3, if3.rd_valid} !== 6'h0)
      $display("FAIL async_reset: got pal_in=%0d busy=%b valid=%b, expected 0 0 0",
               pal_in3, busy3, if3.rd_valid);
    else passes++;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({done3, busy3} !== 2'b00)
        $display("FAIL abort_no_done: got done=%b busy=%b, expected 0 0", done3, busy3);
      else passes++;
    end
    rst = 1'b0;
    fill_random();
    sweep(-1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    sel = 1'b1;
    for (int i = 0; i < 16; i++) tbl[i] = {1'(i % 2), 4'(i)};
    sweep(-1, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    fill_random();
    sweep(-1, 0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_sweep_basic();
    test_backpressure();
    test_start_ignored();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
